// File: rtl/sniffer_pkg.sv
// ---------------------------------------------------------------------------
// sniffer_pkg
// Shared definitions for the Logic Sniffer host link:
//   - opcode constants for short (bit7 = 0) and long (bit7 = 1) commands
//   - dec_state_e : command decoder state
//   - cmd_t       : decoded command {opcode, data}
//   - is_long_op  : helper that classifies an opcode byte
// ---------------------------------------------------------------------------
package sniffer_pkg;

    localparam logic [7:0] OP_RESET      = 8'h00;
    localparam logic [7:0] OP_RUN        = 8'h01;
    localparam logic [7:0] OP_ID         = 8'h02;
    localparam logic [7:0] OP_META       = 8'h04;
    localparam logic [7:0] OP_RLE_FINISH = 8'h05;
    localparam logic [7:0] OP_NOP        = 8'h7F;
    // Long opcodes occupy 8'h80-8'hFF; each is followed by 4 value bytes.
    localparam logic [7:0] OP_LONG_MIN   = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LONG1 = 3'd1,
        ST_LONG2 = 3'd2,
        ST_LONG3 = 3'd3,
        ST_LONG4 = 3'd4
    } dec_state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] data;
    } cmd_t;

    function automatic logic is_long_op(input logic [7:0] b);
        return b[7];
    endfunction

endpackage

// File: rtl/spi_byte_phy.sv
// ---------------------------------------------------------------------------
// spi_byte_phy
// SPI mode 0 byte engine (MSB first) running entirely in the system clock
// domain. The asynchronous SPI pins are synchronised, sclk edges are detected
// on the synchronised copy, and 8-bit rx/tx shift registers are advanced.
//
// Ports
//   clk_i, rst_ni   system clock, asynchronous active-low reset
//   sclk_i          SPI clock (async)
//   cs_n_i          SPI chip select, active low (async)
//   mosi_i          master-out data (async)
//   miso_o          slave-out data (MSB of the tx shift register)
//   rx_byte_stb_o   one-cycle pulse, rx_byte_o holds a complete byte
//   rx_byte_o       last received byte
//   frame_done_o    combinational: the 8th sclk rise is being taken this cycle
//   tx_load_o       tx shift register is loaded from tx_byte_i this cycle
//   tx_byte_i       next byte to transmit (from the holding register)
// ---------------------------------------------------------------------------
module spi_byte_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       rx_byte_stb_o,
    output logic [7:0] rx_byte_o,
    output logic       frame_done_o,
    output logic       tx_load_o,
    input  logic [7:0] tx_byte_i
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall;

    logic [2:0] bit_cnt_q,     bit_cnt_d;
    logic [7:0] rx_sr_q,       rx_sr_d;
    logic [7:0] tx_sr_q,       tx_sr_d;
    logic [7:0] rx_byte_q,     rx_byte_d;
    logic       rx_byte_stb_q, rx_byte_stb_d;

    // Synchroniser chains; cs_n resets to "deselected".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise    = ~cs_s &  sclk_s & ~sclk_prev_q;
    assign sclk_fall    = ~cs_s & ~sclk_s &  sclk_prev_q;
    assign frame_done_o = sclk_rise & (bit_cnt_q == 3'd7);

    // The reload after a completed frame happens one cycle after frame_done,
    // so the holding register has already popped and tx_byte_i is the next byte.
    assign tx_load_o = cs_s | rx_byte_stb_q;

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        rx_sr_d       = rx_sr_q;
        tx_sr_d       = tx_sr_q;
        rx_byte_d     = rx_byte_q;
        rx_byte_stb_d = frame_done_o;
        if (cs_s) begin
            bit_cnt_d = 3'd0;
            tx_sr_d   = tx_byte_i;
        end else begin
            if (sclk_rise) begin
                rx_sr_d   = {rx_sr_q[6:0], mosi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (frame_done_o) begin
                    rx_byte_d = {rx_sr_q[6:0], mosi_s};
                end
            end
            // The fall that ends a frame (count back at 0) must not shift out
            // the MSB of the byte reloaded for the next frame.
            if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
            if (rx_byte_stb_q) begin
                tx_sr_d = tx_byte_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q     <= 3'd0;
            rx_sr_q       <= 8'h00;
            tx_sr_q       <= 8'h00;
            rx_byte_q     <= 8'h00;
            rx_byte_stb_q <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            rx_sr_q       <= rx_sr_d;
            tx_sr_q       <= tx_sr_d;
            rx_byte_q     <= rx_byte_d;
            rx_byte_stb_q <= rx_byte_stb_d;
        end
    end

    assign miso_o        = tx_sr_q[7];
    assign rx_byte_o     = rx_byte_q;
    assign rx_byte_stb_o = rx_byte_stb_q;

endmodule

// File: rtl/spi_slave_cmd.sv
// ---------------------------------------------------------------------------
// spi_slave_cmd
// FPGA-side SPI responder of the Logic Sniffer host link. Decodes short
// (1-byte) and long (opcode + 4-byte LSB-first value) commands and returns
// queued response words on MISO, LSB byte first.
//
// Handshake: a response word is accepted on a cycle where tx_valid and
// tx_ready are both high; tx_ready stays low (and dataReady high) until every
// byte of that word has been clocked out by a completed frame.
//
// Ports
//   bf_clock, reset_n          system clock, asynchronous active-low reset
//   spi_sclk/spi_cs_n/spi_mosi SPI inputs (async), spi_miso SPI output
//   cmd_valid/cmd_opcode/cmd_data  decoded command strobe and value
//   tx_valid/tx_data/tx_bytes/tx_ready  response word input
//   dataReady                  response bytes still pending
//   dbg_state                  decoder state
// ---------------------------------------------------------------------------
module spi_slave_cmd
    import sniffer_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic        bf_clock,
    input  logic        reset_n,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_data,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    input  logic [2:0]  tx_bytes,
    output logic        tx_ready,
    output logic        dataReady,
    output dec_state_e  dbg_state
);

    logic       rx_byte_stb;
    logic [7:0] rx_byte;
    logic       frame_done;
    logic       tx_load;
    logic [7:0] tx_byte;

    spi_byte_phy #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_phy (
        .clk_i         (bf_clock),
        .rst_ni        (reset_n),
        .sclk_i        (spi_sclk),
        .cs_n_i        (spi_cs_n),
        .mosi_i        (spi_mosi),
        .miso_o        (spi_miso),
        .rx_byte_stb_o (rx_byte_stb),
        .rx_byte_o     (rx_byte),
        .frame_done_o  (frame_done),
        .tx_load_o     (tx_load),
        .tx_byte_i     (tx_byte)
    );

    // ---------------- tx holding register ----------------
    logic [31:0] hold_data_q, hold_data_d;
    logic [2:0]  hold_cnt_q,  hold_cnt_d;
    // Set when the byte in the phy shift register came from the holding
    // register, so a frame carrying IDLE_BYTE never consumes a queued byte.
    logic        inflight_q,  inflight_d;
    logic [2:0]  tx_len;

    assign tx_len    = ((tx_bytes == 3'd0) || (tx_bytes > 3'd4)) ? 3'd4 : tx_bytes;
    assign tx_ready  = (hold_cnt_q == 3'd0);
    assign dataReady = (hold_cnt_q != 3'd0);
    assign tx_byte   = dataReady ? hold_data_q[7:0] : IDLE_BYTE;

    always_comb begin
        hold_data_d = hold_data_q;
        hold_cnt_d  = hold_cnt_q;
        inflight_d  = inflight_q;
        if (tx_load) begin
            inflight_d = dataReady;
        end
        if (tx_valid && tx_ready) begin
            hold_data_d = tx_data;
            hold_cnt_d  = tx_len;
        end else if (frame_done && inflight_q && dataReady) begin
            hold_data_d = {8'h00, hold_data_q[31:8]};
            hold_cnt_d  = hold_cnt_q - 3'd1;
        end
    end

    always_ff @(posedge bf_clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_data_q <= 32'h0;
            hold_cnt_q  <= 3'd0;
            inflight_q  <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_cnt_q  <= hold_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

    // ---------------- command decoder ----------------
    dec_state_e state_q, state_d;
    cmd_t       long_q,  long_d;   // long command being assembled
    cmd_t       cmd_q,   cmd_d;    // presented command, held between strobes
    logic       cmd_valid_q, cmd_valid_d;

    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        if (rx_byte_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_long_op(rx_byte)) begin
                        long_d.opcode = rx_byte;
                        long_d.data   = 32'h0;
                        state_d       = ST_LONG1;
                    end else begin
                        cmd_d.opcode = rx_byte;
                        cmd_d.data   = 32'h0;
                        cmd_valid_d  = 1'b1;
                    end
                end
                ST_LONG1: begin
                    long_d.data[7:0] = rx_byte;
                    state_d          = ST_LONG2;
                end
                ST_LONG2: begin
                    long_d.data[15:8] = rx_byte;
                    state_d           = ST_LONG3;
                end
                ST_LONG3: begin
                    long_d.data[23:16] = rx_byte;
                    state_d            = ST_LONG4;
                end
                ST_LONG4: begin
                    cmd_d.opcode = long_q.opcode;
                    cmd_d.data   = {rx_byte, long_q.data[23:0]};
                    cmd_valid_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge bf_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            long_q      <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_opcode = cmd_q.opcode;
    assign cmd_data   = cmd_q.data;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_slave_cmd.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_cmd
// Directed bench for spi_slave_cmd: drives an SPI mode 0 master and a
// response-word producer, and checks decoded commands, MISO bytes and the
// holding register flags against hand-computed values.
// ---------------------------------------------------------------------------
module tb_spi_slave_cmd;
    import sniffer_pkg::*;

    localparam int HALF = 6;   // sclk half period in bf_clock cycles

    // ---------------- clock / reset ----------------
    logic bf_clock = 1'b0;
    logic reset_n  = 1'b0;
    always #10 bf_clock = ~bf_clock;

    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        tx_valid = 1'b0;
    logic [31:0] tx_data  = 32'h0;
    logic [2:0]  tx_bytes = 3'd0;
    logic        tx_ready;
    logic        dataReady;
    dec_state_e  dbg_state;

    spi_slave_cmd dut (
        .bf_clock   (bf_clock),
        .reset_n    (reset_n),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .cmd_valid  (cmd_valid),
        .cmd_opcode (cmd_opcode),
        .cmd_data   (cmd_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_bytes   (tx_bytes),
        .tx_ready   (tx_ready),
        .dataReady  (dataReady),
        .dbg_state  (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- strobe monitor ----------------
    int          stb_cnt  = 0;
    int          dbl_cnt  = 0;
    logic        prev_vld = 1'b0;
    logic [7:0]  last_op  = 8'h00;
    logic [31:0] last_dat = 32'h0;

    always @(negedge bf_clock) begin
        if (cmd_valid === 1'b1) begin
            stb_cnt++;
            last_op  = cmd_opcode;
            last_dat = cmd_data;
        end
        if ((cmd_valid === 1'b1) && prev_vld) dbl_cnt++;
        prev_vld = (cmd_valid === 1'b1);
    end

    // ---------------- check / driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        repeat (HALF) @(negedge bf_clock);
        m = spi_miso;
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge bf_clock);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n);
        logic m;
        for (int i = 0; i < n; i++) spi_bit(tx[7-i], m);
    endtask

    task automatic frame(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
        repeat (4) @(negedge bf_clock);
    endtask

    task automatic cs_lo();
        spi_cs_n = 1'b0;
        repeat (4) @(negedge bf_clock);
    endtask

    task automatic cs_hi();
        spi_cs_n = 1'b1;
        repeat (8) @(negedge bf_clock);
    endtask

    task automatic push_word(input logic [31:0] d, input logic [2:0] n);
        chk("push_tx_ready", {31'h0, tx_ready}, 32'h1);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_bytes = n;
        @(negedge bf_clock);
        tx_valid = 1'b0;
        chk("push_dataReady", {31'h0, dataReady}, 32'h1);
        chk("push_tx_ready_low", {31'h0, tx_ready}, 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] rx;
    int exp_stb;

    initial begin
        exp_stb = 0;
        repeat (5) @(negedge bf_clock);
        reset_n = 1'b1;
        repeat (6) @(negedge bf_clock);

        // reset state
        chk("rst_miso",      {31'h0, spi_miso},  32'h0);
        chk("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
        chk("rst_opcode",    {24'h0, cmd_opcode}, 32'h0);
        chk("rst_data",      cmd_data, 32'h0);
        chk("rst_tx_ready",  {31'h0, tx_ready},  32'h1);
        chk("rst_dataReady", {31'h0, dataReady}, 32'h0);
        chk("rst_state",     {29'h0, dbg_state}, {29'h0, ST_IDLE});

        // 1: short command, partial frame produces nothing
        cs_lo();
        spi_bits(8'h82, 4);
        cs_hi();
        chk("t1_partial_stb", stb_cnt, exp_stb);
        chk("t1_partial_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        cs_lo();
        frame(8'h02, rx); exp_stb++;
        chk("t1_stb", stb_cnt, exp_stb);
        chk("t1_op", {24'h0, last_op}, 32'h02);
        chk("t1_data", last_dat, 32'h0);
        chk("t1_hold_op", {24'h0, cmd_opcode}, 32'h02);
        cs_hi();

        // 2: long command C1 40 00 00 00
        cs_lo();
        frame(8'hC1, rx);
        chk("t2_state1", {29'h0, dbg_state}, {29'h0, ST_LONG1});
        chk("t2_hold_op", {24'h0, cmd_opcode}, 32'h02);
        frame(8'h40, rx);
        frame(8'h00, rx);
        frame(8'h00, rx);
        chk("t2_no_stb", stb_cnt, exp_stb);
        chk("t2_state4", {29'h0, dbg_state}, {29'h0, ST_LONG4});
        frame(8'h00, rx); exp_stb++;
        chk("t2_stb", stb_cnt, exp_stb);
        chk("t2_op", {24'h0, last_op}, 32'hC1);
        chk("t2_data", last_dat, 32'h00000040);
        chk("t2_state_idle", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        cs_hi();

        // 3: response "1ALS" over four frames, then idle byte
        push_word(32'h534C4131, 3'd4);
        repeat (4) @(negedge bf_clock);
        cs_lo();
        frame(8'h7F, rx); exp_stb++;
        chk("t3_b0", {24'h0, rx}, 32'h31);
        frame(8'h7F, rx); exp_stb++;
        chk("t3_b1", {24'h0, rx}, 32'h41);
        frame(8'h7F, rx); exp_stb++;
        chk("t3_b2", {24'h0, rx}, 32'h4C);
        chk("t3_dr_mid", {31'h0, dataReady}, 32'h1);
        frame(8'h7F, rx); exp_stb++;
        chk("t3_b3", {24'h0, rx}, 32'h53);
        chk("t3_dr_end", {31'h0, dataReady}, 32'h0);
        chk("t3_ready_end", {31'h0, tx_ready}, 32'h1);
        frame(8'h7F, rx); exp_stb++;
        chk("t3_idle", {24'h0, rx}, 32'h00);
        chk("t3_stb", stb_cnt, exp_stb);
        chk("t3_op", {24'h0, last_op}, 32'h7F);
        cs_hi();

        // 4: resync with five 0x00 after an open long command
        cs_lo();
        frame(8'h82, rx);
        frame(8'h11, rx);
        frame(8'h00, rx);
        frame(8'h00, rx);
        chk("t4_no_stb", stb_cnt, exp_stb);
        frame(8'h00, rx); exp_stb++;
        chk("t4_stb_long", stb_cnt, exp_stb);
        chk("t4_long_op", {24'h0, last_op}, 32'h82);
        chk("t4_long_data", last_dat, 32'h00000011);
        frame(8'h00, rx); exp_stb++;
        chk("t4_short4_op", {24'h0, last_op}, 32'h00);
        chk("t4_short4_data", last_dat, 32'h0);
        frame(8'h00, rx); exp_stb++;
        chk("t4_stb_final", stb_cnt, exp_stb);
        chk("t4_short5_op", {24'h0, last_op}, 32'h00);
        chk("t4_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        cs_hi();

        // 5: aborted frame keeps the queued byte
        push_word(32'h000000A5, 3'd1);
        repeat (4) @(negedge bf_clock);
        cs_lo();
        spi_bits(8'h7F, 4);
        cs_hi();
        chk("t5_dr_kept", {31'h0, dataReady}, 32'h1);
        chk("t5_no_stb", stb_cnt, exp_stb);
        cs_lo();
        frame(8'h7F, rx); exp_stb++;
        chk("t5_resent", {24'h0, rx}, 32'hA5);
        chk("t5_dr_pop", {31'h0, dataReady}, 32'h0);
        chk("t5_stb", stb_cnt, exp_stb);
        cs_hi();

        // 6: tx_bytes=0 sends four bytes; then reset mid long command
        push_word(32'hDDCCBBAA, 3'd0);
        repeat (4) @(negedge bf_clock);
        cs_lo();
        frame(8'h81, rx);
        chk("t6_b0", {24'h0, rx}, 32'hAA);
        frame(8'h05, rx);
        chk("t6_b1", {24'h0, rx}, 32'hBB);
        frame(8'h06, rx);
        chk("t6_b2", {24'h0, rx}, 32'hCC);
        chk("t6_dr_mid", {31'h0, dataReady}, 32'h1);
        frame(8'h07, rx);
        chk("t6_b3", {24'h0, rx}, 32'hDD);
        chk("t6_dr_end", {31'h0, dataReady}, 32'h0);
        frame(8'h08, rx); exp_stb++;
        chk("t6_long_op", {24'h0, last_op}, 32'h81);
        chk("t6_long_data", last_dat, 32'h08070605);
        cs_hi();
        push_word(32'h0000EEFF, 3'd2);
        repeat (4) @(negedge bf_clock);
        cs_lo();
        frame(8'hC0, rx);
        chk("t6_c0_rx", {24'h0, rx}, 32'hFF);
        chk("t6_c0_state", {29'h0, dbg_state}, {29'h0, ST_LONG1});
        spi_bits(8'hFF, 3);
        reset_n = 1'b0;
        repeat (2) @(negedge bf_clock);
        chk("t6_rst_miso",      {31'h0, spi_miso},  32'h0);
        chk("t6_rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
        chk("t6_rst_opcode",    {24'h0, cmd_opcode}, 32'h0);
        chk("t6_rst_data",      cmd_data, 32'h0);
        chk("t6_rst_tx_ready",  {31'h0, tx_ready},  32'h1);
        chk("t6_rst_dataReady", {31'h0, dataReady}, 32'h0);
        chk("t6_rst_state",     {29'h0, dbg_state}, {29'h0, ST_IDLE});
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        reset_n  = 1'b1;
        repeat (8) @(negedge bf_clock);
        cs_lo();
        frame(8'h01, rx); exp_stb++;
        chk("t6_lost_resp", {24'h0, rx}, 32'h00);
        chk("t6_post_stb", stb_cnt, exp_stb);
        chk("t6_post_op", {24'h0, last_op}, 32'h01);
        chk("t6_post_data", last_dat, 32'h0);
        chk("t6_post_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        cs_hi();

        chk("single_cycle_strobe", dbl_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
